// File: rtl/pulse_divider_if.sv
//------------------------------------------------------------------------------
// Module      : pulse_divider_if
// Description : Pulse-train and register bus for the pulse divider. The
//               master side drives the pulse input, enable and register
//               writes; the slave side (the divider) returns the routed
//               pulses and the live count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pulse_divider_if #(
  parameter int CW = 32
);
  logic          inp_i;
  logic          enable_i;
  logic [CW-1:0] DIVISOR;
  logic          DIVISOR_WSTB;
  logic          FIRST_PULSE;
  logic          FIRST_PULSE_WSTB;
  logic          outd_o;
  logic          outn_o;
  logic [CW-1:0] COUNT;

  modport master (
    output inp_i, enable_i, DIVISOR, DIVISOR_WSTB, FIRST_PULSE, FIRST_PULSE_WSTB,
    input  outd_o, outn_o, COUNT
  );

  modport slave (
    input  inp_i, enable_i, DIVISOR, DIVISOR_WSTB, FIRST_PULSE, FIRST_PULSE_WSTB,
    output outd_o, outn_o, COUNT
  );
endinterface

`default_nettype wire

// File: rtl/pulse_divider.sv
//------------------------------------------------------------------------------
// Module      : pulse_divider
// Description : Routes every DIVISOR-th rising edge of the input pulse train
//               to outd_o and all other pulses to outn_o, preserving pulse
//               shape with one clock of latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_divider #(
  parameter int CW = 32
) (
  input wire             clk_i,
  input wire             reset_i,
  pulse_divider_if.slave bus
);

  localparam logic [CW-1:0] C_ONE = CW'(1);

  // ROUTE_NONE marks a pulse that was swallowed by a reload (or was already
  // high when the block was enabled): it must stay silent until its next edge.
  typedef enum logic [1:0] {
    ROUTE_NONE = 2'd0,
    ROUTE_N    = 2'd1,
    ROUTE_D    = 2'd2
  } route_t;

  route_t        route_q, route_d;
  logic          inp_q, inp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          outd_q, outd_d;
  logic          outn_q, outn_d;

  logic [CW-1:0] deff;
  logic [CW-1:0] last;
  logic [CW-1:0] init;
  logic          reload;
  logic          rise;

  // Effective divisor, reload value and edge detect from the live register inputs.
  always_comb begin
    deff   = (bus.DIVISOR == '0) ? C_ONE : bus.DIVISOR;
    last   = deff - C_ONE;
    init   = bus.FIRST_PULSE ? last : '0;
    reload = ~bus.enable_i | bus.DIVISOR_WSTB | bus.FIRST_PULSE_WSTB;
    rise   = bus.inp_i & ~inp_q;
  end

  // Next-state: reload beats edges; on an edge pick the route, then gate the pulse through it.
  always_comb begin
    inp_d   = bus.inp_i;
    cnt_d   = cnt_q;
    route_d = route_q;
    outd_d  = 1'b0;
    outn_d  = 1'b0;
    if (reload) begin
      cnt_d   = init;
      route_d = ROUTE_NONE;
    end else begin
      if (rise) begin
        // >= also catches a counter left above a DIVISOR lowered without a strobe.
        if (cnt_q >= last) begin
          route_d = ROUTE_D;
          cnt_d   = '0;
        end else begin
          route_d = ROUTE_N;
          cnt_d   = cnt_q + C_ONE;
        end
      end
      outd_d = bus.inp_i & (route_d == ROUTE_D);
      outn_d = bus.inp_i & (route_d == ROUTE_N);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inp_q   <= 1'b0;
      cnt_q   <= '0;
      route_q <= ROUTE_N;
      outd_q  <= 1'b0;
      outn_q  <= 1'b0;
    end else begin
      inp_q   <= inp_d;
      cnt_q   <= cnt_d;
      route_q <= route_d;
      outd_q  <= outd_d;
      outn_q  <= outn_d;
    end
  end

  assign bus.outd_o = outd_q;
  assign bus.outn_o = outn_q;
  assign bus.COUNT  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_pulse_divider
// Description : Self-checking bench for pulse_divider. Inputs change just
//               after the falling edge; outputs are sampled on the following
//               falling edge, one rising edge later.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_divider;

  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset_i;

  pulse_divider_if #(.CW(CW)) ifc ();

  pulse_divider #(.CW(CW)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          inp;
    bit          en;
    bit          dw;
    bit          fw;
    int          div;
    bit          d;
    bit          n;
    logic [CW-1:0] cnt;
  } stim_t;

  typedef struct {
    bit            d;
    bit            n;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic stim_t mk(bit inp, bit en, bit dw, bit fw, int div,
                               bit d, bit n, int cnt);
    stim_t s;
    s.inp = inp; s.en = en; s.dw = dw; s.fw = fw; s.div = div;
    s.d = d; s.n = n; s.cnt = CW'(cnt);
    return s;
  endfunction

  // Drive one cycle of stimulus and record what the DUT must show after the next edge.
  task automatic apply(input stim_t s, input string name, input int idx);
    ifc.inp_i            = s.inp;
    ifc.enable_i         = s.en;
    ifc.DIVISOR_WSTB     = s.dw;
    ifc.FIRST_PULSE_WSTB = s.fw;
    ifc.DIVISOR          = CW'(s.div);
    sb.push_back('{d: s.d, n: s.n, cnt: s.cnt, tag: $sformatf("%s[%0d]", name, idx)});
  endtask

  task automatic test_reset();
    reset_i              = 1'b1;
    ifc.inp_i            = 1'b0;
    ifc.enable_i         = 1'b0;
    ifc.DIVISOR          = CW'(3);
    ifc.DIVISOR_WSTB     = 1'b0;
    ifc.FIRST_PULSE      = 1'b0;
    ifc.FIRST_PULSE_WSTB = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {1'b0, 1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL reset: got d=%b n=%b count=%0d, expected d=0 n=0 count=0",
               ifc.outd_o, ifc.outn_o, ifc.COUNT);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_basic_divide();
    stim_t st[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b0;
    st.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0));
    for (int p = 0; p < 6; p++) begin
      st.push_back(mk(1, 1, 0, 0, 3, (p % 3) == 2, (p % 3) != 2, (p + 1) % 3));
      st.push_back(mk(0, 1, 0, 0, 3, 0, 0, (p + 1) % 3));
    end
    foreach (st[i]) begin
      apply(st[i], "basic", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  task automatic test_first_pulse();
    stim_t st[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b1;
    st.push_back(mk(0, 1, 0, 1, 3, 0, 0, 2));
    for (int p = 0; p < 4; p++) begin
      st.push_back(mk(1, 1, 0, 0, 3, (p % 3) == 0, (p % 3) != 0, p % 3));
      st.push_back(mk(0, 1, 0, 0, 3, 0, 0, p % 3));
    end
    foreach (st[i]) begin
      apply(st[i], "first_pulse", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  task automatic test_enable_gating();
    stim_t st[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b0;
    st.push_back(mk(0, 1, 0, 1, 4, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 4, 0, 1, 1));
    st.push_back(mk(0, 1, 0, 0, 4, 0, 0, 1));
    st.push_back(mk(1, 1, 0, 0, 4, 0, 1, 2));
    st.push_back(mk(0, 1, 0, 0, 4, 0, 0, 2));
    st.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0));   // enable low one cycle
    // five-cycle pulse, enable dropped on its third cycle
    st.push_back(mk(1, 1, 0, 0, 4, 0, 1, 1));
    st.push_back(mk(1, 1, 0, 0, 4, 0, 1, 1));
    st.push_back(mk(1, 0, 0, 0, 4, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 4, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 4, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 0, 4, 0, 0, 0));
    for (int p = 0; p < 4; p++) begin
      st.push_back(mk(1, 1, 0, 0, 4, p == 3, p != 3, (p + 1) % 4));
      st.push_back(mk(0, 1, 0, 0, 4, 0, 0, (p + 1) % 4));
    end
    foreach (st[i]) begin
      apply(st[i], "enable", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  task automatic test_divisor_corner();
    stim_t st[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b0;
    for (int dv = 0; dv < 2; dv++) begin
      st.push_back(mk(0, 1, 1, 0, dv, 0, 0, 0));
      for (int p = 0; p < 3; p++) begin
        st.push_back(mk(1, 1, 0, 0, dv, 1, 0, 0));
        st.push_back(mk(0, 1, 0, 0, dv, 0, 0, 0));
      end
    end
    foreach (st[i]) begin
      apply(st[i], "div_corner", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  task automatic test_divisor_change();
    stim_t st[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b0;
    st.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 3, 0, 1, 1));
    st.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    st.push_back(mk(1, 1, 0, 0, 3, 0, 1, 2));
    st.push_back(mk(0, 1, 0, 0, 2, 0, 0, 2));   // lowered without strobe: no reload
    st.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0));   // counter 2 >= 1 -> divided
    st.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 2, 0, 1, 1));
    st.push_back(mk(0, 1, 0, 0, 2, 0, 0, 1));
    st.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0));
    st.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i], "div_change", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  task automatic test_collision();
    stim_t st[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b0;
    st.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 3, 0, 1, 1));
    st.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    st.push_back(mk(1, 1, 1, 0, 3, 0, 0, 0));   // edge together with strobe
    st.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0));   // still high: swallowed
    st.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 3, 0, 1, 1));
    st.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    foreach (st[i]) begin
      apply(st[i], "collision", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st[$];
    stim_t post[$];
    exp_t  e;
    ifc.FIRST_PULSE = 1'b0;
    st.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 3, 0, 1, 1));
    st.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    st.push_back(mk(1, 1, 0, 0, 3, 0, 1, 2));   // outn high, count 2
    foreach (st[i]) begin
      apply(st[i], "pre_reset", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
    // Assert reset mid-cycle, well away from any rising edge.
    #2;
    reset_i   = 1'b1;
    ifc.inp_i = 1'b0;
    #1;
    checks++;
    if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {1'b0, 1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL async_reset: got d=%b n=%b count=%0d, expected d=0 n=0 count=0",
               ifc.outd_o, ifc.outn_o, ifc.COUNT);
    end
    @(negedge clk);
    reset_i = 1'b0;
    post.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0));
    post.push_back(mk(1, 1, 0, 0, 3, 0, 1, 1));
    post.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    post.push_back(mk(1, 1, 0, 0, 3, 0, 1, 2));
    post.push_back(mk(0, 1, 0, 0, 3, 0, 0, 2));
    post.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0));
    post.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0));
    foreach (post[i]) begin
      apply(post[i], "post_reset", i);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifc.outd_o, ifc.outn_o, ifc.COUNT} !== {e.d, e.n, e.cnt}) begin
        errors++;
        $display("FAIL %s: got d=%b n=%b count=%0d, expected d=%b n=%b count=%0d",
                 e.tag, ifc.outd_o, ifc.outn_o, ifc.COUNT, e.d, e.n, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_divide();
    test_first_pulse();
    test_enable_gating();
    test_divisor_corner();
    test_divisor_change();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_divider.md
Name: pulse_divider

Overview:
Pulse-train divider for the position/timing bus. Every DIVISOR-th rising edge on inp_i is routed to outd_o; all other pulses are routed to outn_o. Input pulse shape is preserved with one clock of latency. A register interface sets the divisor and the first-pulse policy, and reads back the live count.

Parameters:
CW, 32, counter/divisor width in bits (DIVISOR and COUNT are CW wide)

Ports:
clk_i  in  1  system clock, all logic on rising edge
reset_i  in  1  reset, asynchronous, active-high
inp_i  in  1  input pulse train
enable_i  in  1  block enable; low holds block idle and reloads counter
DIVISOR  in  CW  divide ratio (register)
DIVISOR_WSTB  in  1  one-cycle write strobe for DIVISOR; reloads counter
FIRST_PULSE  in  1  0: first pulse goes to outn_o; 1: first pulse goes to outd_o
FIRST_PULSE_WSTB  in  1  one-cycle write strobe for FIRST_PULSE; reloads counter
outd_o  out  1  divided output (every DIVISOR-th pulse)
outn_o  out  1  non-divided output (all other pulses)
COUNT  out  CW  current counter value (register readback)

Behaviour:
- Clocking and reset: one clock (clk_i). reset_i is asynchronous and active-high.
- On reset: outd_o=0, outn_o=0, inp_i delay register=0, route flag=N, counter=0, COUNT=0.
- Effective divisor Deff = max(DIVISOR,1). DIVISOR values 0 and 1 both route every pulse to outd_o.
- Initial counter value INIT:
  - INIT = 0 when FIRST_PULSE=0.
  - INIT = Deff-1 when FIRST_PULSE=1.
  - INIT uses the current DIVISOR and FIRST_PULSE input values.
- Reload condition: counter<=INIT, and both outputs are driven 0 on the next edge, when any of the following holds:
  - enable_i=0;
  - DIVISOR_WSTB=1;
  - FIRST_PULSE_WSTB=1.
- Rising edge detection: rise = inp_i & ~inp_d, where inp_d is inp_i registered.
- Rising edge with enable_i=1 and no reload:
  - If counter >= Deff-1: route flag<=D and counter<=0.
  - Otherwise: route flag<=N and counter<=counter+1.
- Outputs are registered:
  - outd_o <= inp_i & enable_i & (route selected = D).
  - outn_o <= inp_i & enable_i & (route selected = N).
  - On the edge cycle, the route is the newly chosen one. Thereafter the route flag holds until the next rising edge.
  - Result: each output pulse rises one clock after inp_i rises and falls one clock after inp_i falls.
  - outd_o and outn_o are never high simultaneously.
- Latency: inp_i to output = 1 clock. COUNT equals the counter register, updated on the same edge (no extra delay).
- Precedence: reset_i > reload (enable low / strobes) > input edge. A rising edge coinciding with a reload is discarded. No output is produced for that pulse, even if inp_i stays high afterwards.
- Enable dropping mid-pulse: the output goes low on the next edge. Pulses already high when enable_i rises produce no output (no edge is seen).
- DIVISOR changed without a strobe: the new Deff applies at the next comparison and the counter is not reloaded. A counter above the new Deff-1 is caught by the >= test, so the next pulse goes to outd_o.
- Counter arithmetic is unsigned CW-bit. The counter never exceeds Deff-1 after a rising edge, so no wrap is possible.

Test Plan:
- Basic divide:
  - Setup: DIVISOR=3, FIRST_PULSE=0, enable_i=1, six 1-cycle pulses.
  - Routing: pulses 1,2 -> outn_o; pulse 3 -> outd_o; pulses 4,5 -> outn_o; pulse 6 -> outd_o.
  - COUNT after each pulse: 1,2,0,1,2,0.
  - Each output pulse is 1 cycle wide, delayed 1 clock.
- First-pulse policy: DIVISOR=3, FIRST_PULSE=1 with FIRST_PULSE_WSTB -> COUNT=2 after reload; pulse 1 -> outd_o; pulses 2,3 -> outn_o; pulse 4 -> outd_o.
- Enable gating:
  - DIVISOR=4, FIRST_PULSE=0, two pulses (COUNT=2).
  - Drop enable_i for 1 cycle -> COUNT=0.
  - A 5-cycle pulse in flight is cut to low 1 clock after enable_i falls.
  - After re-enable, the next 3 pulses go to outn_o and the 4th goes to outd_o.
- Divisor corner: DIVISOR=0, then DIVISOR=1 -> every pulse on outd_o, outn_o stays 0, COUNT stays 0.
- Strobe/edge collision: DIVISOR_WSTB asserted on the same cycle as an inp_i rising edge -> no output for that pulse, and COUNT=INIT.
- Async reset: assert reset_i between clock edges while outn_o=1 and COUNT=2 -> outputs and COUNT go to 0 immediately. After release, counting restarts from INIT.
